uart_move_rx: RTL and testbench

// Oversampling UART receiver for the 8-bit move link between the two boards (jb[0] in, ja[0] out).

---
 rtl/uart_move_rx.sv | 196 +++++++++++++++++++
 tb/tb_uart_move_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_move_rx.sv
// Oversampling 8N1 receiver for the inter-board move link: recovers one byte per frame,
// pulsing ready on a good stop bit or frame_err on a low one, and arms only after a long idle gap.
module uart_move_rx #(
    parameter int CLK_PER_SAMP  = 423,
    parameter int SAMP_PER_BIT  = 16,
    parameter int PKT_LEN       = 8,
    parameter int WAITING_COUNT = 65_000
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rx,
    output logic               ready,
    output logic [PKT_LEN-1:0] data_out,
    output logic               frame_err,
    output logic               busy
);

    localparam int TICK_W = $clog2(CLK_PER_SAMP);
    localparam int SAMP_W = $clog2(SAMP_PER_BIT);
    localparam int BIT_W  = $clog2(PKT_LEN);
    localparam int IDLE_W = $clog2(WAITING_COUNT);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [SAMP_W-1:0]    samp_cnt_q, samp_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]           votes_q, votes_d;
    logic                 bit_val_q, bit_val_d;
    logic                 have_vote_q, have_vote_d;
    logic [PKT_LEN-1:0]   shift_q, shift_d;
    logic [PKT_LEN-1:0]   data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;

    logic tick, samp_first, samp_second, samp_third, bit_end, vote;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Sample index j of a bit is taken on the tick that advances samp_cnt from j-1 to j,
    // with index 0 at the bit boundary (start-bit detect for the first bit).
    assign tick        = (tick_cnt_q == TICK_W'(CLK_PER_SAMP - 1));
    assign samp_first  = tick && (samp_cnt_q == SAMP_W'(SAMP_PER_BIT / 2 - 2));
    assign samp_second = tick && (samp_cnt_q == SAMP_W'(SAMP_PER_BIT / 2 - 1));
    assign samp_third  = tick && (samp_cnt_q == SAMP_W'(SAMP_PER_BIT / 2));
    assign bit_end     = tick && (samp_cnt_q == SAMP_W'(SAMP_PER_BIT - 1));
    assign vote        = maj3(votes_q[1], votes_q[0], rx_s_q);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= WAIT_IDLE;
            idle_cnt_q  <= '0;
            tick_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            votes_q     <= '0;
            bit_val_q   <= 1'b0;
            have_vote_q <= 1'b0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            votes_q     <= votes_d;
            bit_val_q   <= bit_val_d;
            have_vote_q <= have_vote_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
        samp_cnt_d  = samp_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        votes_d     = votes_q;
        bit_val_d   = bit_val_q;
        have_vote_d = have_vote_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ready_d     = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = busy_q;

        if (tick) begin
            samp_cnt_d = bit_end ? '0 : samp_cnt_q + SAMP_W'(1);
        end
        if (samp_first) begin
            votes_d[0] = rx_s_q;
        end
        if (samp_second) begin
            votes_d[1] = rx_s_q;
        end

        case (state_q)
            WAIT_IDLE: begin
                if (!rx_s_q) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_W'(WAITING_COUNT - 1)) begin
                    idle_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d    = START;
                    busy_d     = 1'b1;
                    tick_cnt_d = '0;
                    samp_cnt_d = '0;
                end
            end
            START: begin
                if (samp_third) begin
                    if (!vote) begin
                        state_d     = DATA;
                        bit_cnt_d   = '0;
                        have_vote_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            // The first bit_end seen here closes the start bit; have_vote gates it out.
            DATA: begin
                if (samp_third) begin
                    bit_val_d   = vote;
                    have_vote_d = 1'b1;
                end
                if (bit_end && have_vote_q) begin
                    shift_d     = {bit_val_q, shift_q[PKT_LEN-1:1]};
                    have_vote_d = 1'b0;
                    if (bit_cnt_q == BIT_W'(PKT_LEN - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (samp_third) begin
                    busy_d = 1'b0;
                    if (vote) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        idle_cnt_d  = '0;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    assign ready     = ready_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_uart_move_rx.sv
// Directed bench for uart_move_rx with scaled timing: 4 clocks per tick, 64 clocks per bit,
// and a 600-clock arming gap standing in for 1 ms (so "1.1 ms" is 660 clocks).
module tb_uart_move_rx;

    localparam int CPS = 4;
    localparam int SPB = 16;
    localparam int WC  = 600;
    localparam int BIT = CPS * SPB;

    logic       clk_in;
    logic       rst_n_in;
    logic       rx;
    logic       ready;
    logic [7:0] data_out;
    logic       frame_err;
    logic       busy;

    int applied  = 0;
    int failures = 0;

    int readyCnt  = 0;
    int ferrCnt   = 0;
    int busyCnt   = 0;
    int bothHigh  = 0;
    int consec    = 0;
    logic prevPulse = 1'b0;

    typedef struct {
        int         preIdle;
        logic [7:0] data;
        logic       stopBit;
        int         period;
        int         expReady;
        int         expFerr;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs[15];

    uart_move_rx #(
        .CLK_PER_SAMP (CPS),
        .SAMP_PER_BIT (SPB),
        .PKT_LEN      (8),
        .WAITING_COUNT(WC)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rx       (rx),
        .ready    (ready),
        .data_out (data_out),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Pulse monitor on the falling edge, away from the DUT's active edge.
    always @(negedge clk_in) begin
        if (ready === 1'b1) readyCnt++;
        if (frame_err === 1'b1) ferrCnt++;
        if (busy === 1'b1) busyCnt++;
        if (ready === 1'b1 && frame_err === 1'b1) bothHigh++;
        if ((ready === 1'b1 || frame_err === 1'b1) && prevPulse) consec++;
        prevPulse = (ready === 1'b1 || frame_err === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk_in);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic val, input int period);
        rx = val;
        waitCycles(period);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit, input int period);
        sendBit(1'b0, period);
        for (int i = 0; i < 8; i++) sendBit(data[i], period);
        sendBit(stopBit, period);
    endtask

    task automatic applyStimulus(input vec_t v);
        rx = 1'b1;
        waitCycles(v.preIdle);
        sendFrame(v.data, v.stopBit, v.period);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " ready"}, {31'd0, ready}, 32'd0);
        checkOutput({tag, " frame_err"}, {31'd0, frame_err}, 32'd0);
        checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " data_out"}, {24'd0, data_out}, 32'd0);
    endtask

    initial begin
        int r0, f0, b0;

        // Line low from reset: the first 0x3C must be ignored, the rerun after 1.1 ms accepted.
        vecs[0]  = '{300,  8'h3C, 1'b1, BIT,     0, 0, 8'h00};
        vecs[1]  = '{660,  8'h3C, 1'b1, BIT,     1, 0, 8'h3C};
        vecs[2]  = '{660,  8'hA5, 1'b1, BIT,     1, 0, 8'hA5};
        vecs[3]  = '{0,    8'h81, 1'b0, BIT,     0, 1, 8'hA5};
        vecs[4]  = '{100,  8'h42, 1'b1, BIT,     0, 0, 8'hA5};
        vecs[5]  = '{660,  8'h42, 1'b1, BIT,     1, 0, 8'h42};
        vecs[6]  = '{0,    8'h00, 1'b1, BIT,     1, 0, 8'h00};
        vecs[7]  = '{0,    8'hFF, 1'b1, BIT,     1, 0, 8'hFF};
        vecs[8]  = '{0,    8'h55, 1'b1, BIT,     1, 0, 8'h55};
        vecs[9]  = '{0,    8'h00, 1'b1, BIT - 2, 1, 0, 8'h00};
        vecs[10] = '{0,    8'hFF, 1'b1, BIT - 2, 1, 0, 8'hFF};
        vecs[11] = '{0,    8'h55, 1'b1, BIT - 2, 1, 0, 8'h55};
        vecs[12] = '{0,    8'h00, 1'b1, BIT + 2, 1, 0, 8'h00};
        vecs[13] = '{0,    8'hFF, 1'b1, BIT + 2, 1, 0, 8'hFF};
        vecs[14] = '{0,    8'h55, 1'b1, BIT + 2, 1, 0, 8'h55};

        rst_n_in = 1'b0;
        rx       = 1'b0;
        waitCycles(5);
        checkResetState("reset");
        rst_n_in = 1'b1;

        for (int i = 0; i < 15; i++) begin
            r0 = readyCnt;
            f0 = ferrCnt;
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d ready pulses", i), readyCnt - r0, vecs[i].expReady);
            checkOutput($sformatf("vec%0d frame_err pulses", i), ferrCnt - f0, vecs[i].expFerr);
            checkOutput($sformatf("vec%0d data_out", i), {24'd0, data_out}, {24'd0, vecs[i].expData});
        end

        // Short low glitch while armed: busy rises then drops, no pulses, receiver stays armed.
        r0 = readyCnt;
        f0 = ferrCnt;
        b0 = busyCnt;
        rx = 1'b1;
        waitCycles(20);
        rx = 1'b0;
        waitCycles(3);
        rx = 1'b1;
        waitCycles(60);
        checkOutput("glitch busy seen", {31'd0, (busyCnt - b0) > 0}, 32'd1);
        checkOutput("glitch busy cleared", {31'd0, busy}, 32'd0);
        checkOutput("glitch ready pulses", readyCnt - r0, 32'd0);
        checkOutput("glitch frame_err pulses", ferrCnt - f0, 32'd0);
        sendFrame(8'h99, 1'b1, BIT);
        checkOutput("post-glitch ready pulses", readyCnt - r0, 32'd1);
        checkOutput("post-glitch data_out", {24'd0, data_out}, 32'h99);

        // Reset in the middle of the data bits of 0x77, then a clean 0x12 after re-arming.
        r0 = readyCnt;
        f0 = ferrCnt;
        sendBit(1'b0, BIT);
        for (int i = 0; i < 3; i++) sendBit(1'b1, BIT);
        rst_n_in = 1'b0;
        rx       = 1'b1;
        waitCycles(3);
        checkResetState("mid-frame reset");
        rst_n_in = 1'b1;
        waitCycles(660);
        sendFrame(8'h12, 1'b1, BIT);
        checkOutput("reset-test ready pulses", readyCnt - r0, 32'd1);
        checkOutput("reset-test frame_err pulses", ferrCnt - f0, 32'd0);
        checkOutput("reset-test data_out", {24'd0, data_out}, 32'h12);

        waitCycles(4);
        checkOutput("ready with frame_err together", bothHigh, 32'd0);
        checkOutput("pulses on consecutive cycles", consec, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, failures);
        $finish;
    end

endmodule
